vga_mem_arbiter: RTL

- Shares one single-port synchronous video RAM (text/char buffer) between two requesters: the pixel-fetch path, which is real-time, and a CPU/bus port.
- Display requests always win. CPU accesses are scheduled into cycles the display does not use, qualified by the scan position from the VGA sync generator (hc_i/vc_i).
- CPU writes are posted through a one-entry holding register. CPU reads return through a tagged read pipeline.

---
 rtl/vga_mem_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares one sync video RAM between the real-time display fetch and a CPU port.
// Define VGA_ARB_STEAL_EN to let the CPU use any idle cycle, not only blanking.
module vga_mem_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int BLACK_H = 160,
  parameter int BLACK_V = 45
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [9:0]        hc_i,
  input  logic [9:0]        vc_i,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic [DATA_W-1:0] disp_rdata_o,
  output logic              disp_rvalid_o,
  input  logic              cpu_valid_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ready_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_rvalid_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  localparam logic [1:0] C_IDLE   = 2'd0;
  localparam logic [1:0] C_WAIT   = 2'd1;
  localparam logic [1:0] C_RDWAIT = 2'd2;
  localparam logic [9:0] BH = 10'(BLACK_H);
  localparam logic [9:0] BV = 10'(BLACK_V);

  logic [1:0]        st_q, st_d;
  logic              ready_q;
  logic              c_we_q;
  logic [ADDR_W-1:0] c_addr_q;
  logic [DATA_W-1:0] c_wdata_q;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              s1_v_q, s1_cpu_q, s2_v_q, s2_cpu_q;
  logic              disp_rv_q, cpu_rv_q;
  logic [DATA_W-1:0] disp_rd_q, cpu_rd_q;
  logic              blank, window, cpu_grant, accept, disp_ret, cpu_ret;

  assign blank = (hc_i < BH) || (vc_i < BV);
`ifdef VGA_ARB_STEAL_EN
  assign window = blank || !disp_req_i;
`else
  assign window = blank;
`endif
  // the display always wins; the CPU only takes cycles the display leaves free
  assign cpu_grant = !disp_req_i && (st_q == C_WAIT) && window;
  assign accept    = cpu_valid_i && ready_q;
  assign disp_ret  = s2_v_q && !s2_cpu_q;
  assign cpu_ret   = s2_v_q && s2_cpu_q;

  always_comb begin
    st_d = (st_q == C_IDLE)   ? (accept ? C_WAIT : C_IDLE) :
           (st_q == C_WAIT)   ? (cpu_grant ? (c_we_q ? C_IDLE : C_RDWAIT) : C_WAIT) :
           (st_q == C_RDWAIT) ? (cpu_ret ? C_IDLE : C_RDWAIT) : C_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q        <= C_IDLE;
      ready_q     <= 1'b0;
      c_we_q      <= 1'b0;
      c_addr_q    <= '0;
      c_wdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      s1_v_q      <= 1'b0;
      s1_cpu_q    <= 1'b0;
      s2_v_q      <= 1'b0;
      s2_cpu_q    <= 1'b0;
      disp_rv_q   <= 1'b0;
      cpu_rv_q    <= 1'b0;
      disp_rd_q   <= '0;
      cpu_rd_q    <= '0;
    end else begin
      st_q    <= st_d;
      ready_q <= st_d == C_IDLE;
      if (accept) begin
        c_we_q    <= cpu_we_i;
        c_addr_q  <= cpu_addr_i;
        c_wdata_q <= cpu_wdata_i;
      end
      mem_en_q <= disp_req_i || cpu_grant;
      mem_we_q <= cpu_grant && c_we_q;
      if (disp_req_i) mem_addr_q <= disp_addr_i;
      else if (cpu_grant) begin
        mem_addr_q  <= c_addr_q;
        mem_wdata_q <= c_wdata_q;
      end
      // owner tag follows each read so returning data is steered to its requester
      s1_v_q    <= disp_req_i || (cpu_grant && !c_we_q);
      s1_cpu_q  <= !disp_req_i;
      s2_v_q    <= s1_v_q;
      s2_cpu_q  <= s1_cpu_q;
      disp_rv_q <= disp_ret;
      cpu_rv_q  <= cpu_ret;
      if (disp_ret) disp_rd_q <= mem_rdata_i;
      if (cpu_ret) cpu_rd_q <= mem_rdata_i;
    end
  end

  assign cpu_ready_o   = ready_q;
  assign mem_en_o      = mem_en_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign disp_rvalid_o = disp_rv_q;
  assign disp_rdata_o  = disp_rd_q;
  assign cpu_rvalid_o  = cpu_rv_q;
  assign cpu_rdata_o   = cpu_rd_q;
endmodule
